// File: rtl/fp_sub_seq_if.sv
// Handshake and operand/result bundle for the sequential fp subtractor.
// The master drives start and operands; the slave returns status and the held result.
interface fp_sub_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         invalid;
    logic         overflow;
    logic         underflow;

    modport master (
        output start, a, b,
        input  busy, done, result, invalid, overflow, underflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, invalid, overflow, underflow
    );
endinterface

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE single subtractor (a - b): bit-serial alignment and normalisation,
// truncating, denormals flushed to zero, start/busy/done handshake.
module fp_sub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic         clk,
    input logic         rst,
    fp_sub_seq_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int SUM_W = MAN_W + 2;
    localparam int CNT_W = $clog2(SUM_W + 1);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [EXP_W-1:0] D_MAX    = EXP_W'(SUM_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [W-1:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                             input logic [MAN_W-1:0] f);
        return {s, e, f};
    endfunction

    function automatic logic [W-1:0] sat_inf(input logic s);
        return {s, EXP_ONES, {MAN_W{1'b0}}};
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     result_q, result_d;
    logic             invalid_q, invalid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             sign_q, sign_d;
    logic             effsub_q, effsub_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [SIG_W-1:0] mx_q, mx_d;
    logic [SIG_W-1:0] my_q, my_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    // Operand decode; b's sign is flipped so the rest of the block only adds.
    logic             sa, sbn;
    logic [EXP_W-1:0] ea, eb, ex, ey, dexp, exp_inc;
    logic [MAN_W-1:0] fa, fb, fx, fy;
    logic [W-1:0]     neg_b;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, sx;

    assign sa      = bus.a[W-1];
    assign ea      = bus.a[W-2:MAN_W];
    assign fa      = bus.a[MAN_W-1:0];
    assign sbn     = ~bus.b[W-1];
    assign eb      = bus.b[W-2:MAN_W];
    assign fb      = bus.b[MAN_W-1:0];
    assign neg_b   = {sbn, bus.b[W-2:0]};
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == EXP_ONES) && (fa == '0);
    assign b_inf   = (eb == EXP_ONES) && (fb == '0);
    assign a_nan   = (ea == EXP_ONES) && (fa != '0);
    assign b_nan   = (eb == EXP_ONES) && (fb != '0);
    assign swap    = (bus.b[W-2:0] > bus.a[W-2:0]);
    assign sx      = swap ? sbn : sa;
    assign ex      = swap ? eb : ea;
    assign fx      = swap ? fb : fa;
    assign ey      = swap ? ea : eb;
    assign fy      = swap ? fa : fb;
    assign dexp    = ex - ey;
    assign exp_inc = exp_q + EXP_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        invalid_d   = invalid_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        sign_d      = sign_q;
        effsub_d    = effsub_q;
        exp_d       = exp_q;
        mx_d        = mx_q;
        my_d        = my_q;
        sum_d       = sum_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    result_d    = '0;
                    invalid_d   = 1'b0;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    state_d     = S_DONE;
                    if (a_nan || b_nan || (a_inf && b_inf && (bus.a[W-1] == bus.b[W-1]))) begin
                        result_d  = QNAN;
                        invalid_d = 1'b1;
                    end else if (a_inf) begin
                        result_d = bus.a;
                    end else if (b_inf) begin
                        result_d = neg_b;
                    end else if (a_zero && b_zero) begin
                        result_d = '0;
                    end else if (a_zero) begin
                        result_d = neg_b;
                    end else if (b_zero) begin
                        result_d = bus.a;
                    end else if (dexp >= D_MAX) begin
                        result_d = pack_fp(sx, ex, fx);
                    end else begin
                        sign_d   = sx;
                        effsub_d = sa ^ sbn;
                        exp_d    = ex;
                        mx_d     = {1'b1, fx};
                        my_d     = {1'b1, fy};
                        cnt_d    = dexp[CNT_W-1:0];
                        // Equal exponents need no alignment cycles at all.
                        state_d  = (dexp == '0) ? S_ADD : S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                my_d  = my_q >> 1;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = S_ADD;
            end
            S_ADD: begin
                sum_d   = effsub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                                   : ({1'b0, mx_q} + {1'b0, my_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q == '0) begin
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (sum_q[SUM_W-1]) begin
                    sum_d = sum_q >> 1;
                    exp_d = exp_inc;
                    if (exp_inc == EXP_ONES) begin
                        result_d   = sat_inf(sign_q);
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end else if (!sum_q[SUM_W-2]) begin
                    if (exp_q > EXP_ONE) begin
                        sum_d = sum_q << 1;
                        exp_d = exp_q - EXP_ONE;
                    end else begin
                        result_d    = '0;
                        underflow_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end else begin
                    result_d = pack_fp(sign_q, exp_q, sum_q[MAN_W-1:0]);
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            invalid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            invalid_q   <= invalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Working datapath registers are only meaningful once loaded from IDLE.
    always_ff @(posedge clk) begin
        sign_q   <= sign_d;
        effsub_q <= effsub_d;
        exp_q    <= exp_d;
        mx_q     <= mx_d;
        my_q     <= my_d;
        sum_q    <= sum_d;
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.invalid   = invalid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fp_sub_seq.sv
// Self-checking bench for fp_sub_seq: directed cases, reset/ignored-start behaviour,
// and random operands against an integer-arithmetic reference of a - b.
module tb_fp_sub_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    fp_sub_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_sub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: flags packed as {invalid, overflow, underflow}; lat counts cycles
    // from the start-sampling edge until done is seen.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] fl,
                                  output int lat);
        logic [31:0] nb, x, y;
        int          ea, eb, ex, ey, d, p, sh;
        longint      mx, my, s;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sx;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nb = {~b[31], b[30:0]};
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        fl  = 3'b000;
        lat = 1;
        r   = 32'h0;
        if (a_nan || b_nan || (a_inf && b_inf && a[31] == b[31])) begin
            r = 32'h7FC00000; fl = 3'b100; return;
        end
        if (a_inf) begin r = a; return; end
        if (b_inf) begin r = nb; return; end
        if (a_zero && b_zero) begin r = 32'h0; return; end
        if (a_zero) begin r = nb; return; end
        if (b_zero) begin r = a; return; end
        if (b[30:0] > a[30:0]) begin x = nb; y = a; end
        else begin x = a; y = nb; end
        sx = x[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        d  = ex - ey;
        if (d >= 25) begin r = x; return; end
        mx  = longint'({1'b1, x[22:0]});
        my  = longint'({1'b1, y[22:0]}) >>> d;
        s   = (x[31] == y[31]) ? (mx + my) : (mx - my);
        lat = 3 + d;
        if (s == 0) begin
            r = 32'h0;
        end else if (s >= 64'd16777216) begin
            if (ex + 1 == 255) begin
                r = {sx, 8'hFF, 23'h0}; fl = 3'b010;
            end else begin
                r = {sx, 8'(ex + 1), 23'(s >>> 1)}; lat = lat + 1;
            end
        end else begin
            p = 0;
            for (int i = 0; i < 25; i++) if (s[i]) p = i;
            sh = 23 - p;
            if (sh > ex - 1) begin
                r = 32'h0; fl = 3'b001; lat = lat + ex - 1;
            end else begin
                r = {sx, 8'(ex - sh), 23'(s <<< sh)}; lat = lat + sh;
            end
        end
    endfunction

    // Issue one operation from IDLE and check latency, result, flags and handshake.
    // poke > 0 pulses a second start with other operands at that cycle of the op.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic [2:0] exp_fl,
                         input int exp_lat, input int poke);
        int cyc;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (cyc == poke) begin
                bus.start = 1'b1;
                bus.a     = 32'h40400000;
                bus.b     = 32'hC0000000;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_res"}, bus.result, exp_r);
        chk({tag, "_flg"}, {29'b0, bus.invalid, bus.overflow, bus.underflow}, {29'b0, exp_fl});
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {30'b0, bus.done, bus.busy}, 32'd0);
        chk({tag, "_hold"}, bus.result, exp_r);
    endtask

    logic [31:0] ra, rb, er;
    logic [2:0]  ef;
    int          el, sel, expa, expb;

    initial begin
        bus.start = 1'b0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", bus.result, 32'h0);
        chk("rst_ctl", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("rst_flags", {29'b0, bus.invalid, bus.overflow, bus.underflow}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        do_op("sub3m1",  32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 4, 0);
        do_op("sub1m1",  32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000, 3, 0);
        do_op("carry",   32'h3F800000, 32'hBF800000, 32'h40000000, 3'b000, 4, 0);
        do_op("lshift",  32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 3'b000, 27, 0);
        do_op("ovf",     32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3'b010, 3, 0);
        do_op("infinf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100, 1, 0);
        do_op("zero_a",  32'h00000000, 32'h3F800000, 32'hBF800000, 3'b000, 1, 0);
        do_op("far",     32'h4B800000, 32'h33800000, 32'h4B800000, 3'b000, 1, 0);
        do_op("ignore",  32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 3'b000, 27, 5);

        // Reset while aligning: everything returns to idle at once.
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h3F7FFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ctl", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("midrst_res", bus.result, 32'h0);
        chk("midrst_flg", {29'b0, bus.invalid, bus.overflow, bus.underflow}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("after_rst", 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 4, 0);

        for (int i = 0; i < 60; i++) begin
            sel  = int'($urandom_range(0, 9));
            expa = int'($urandom_range(1, 254));
            expb = expa + int'($urandom_range(0, 6)) - 3;
            if (expb < 1) expb = 1;
            if (expb > 254) expb = 254;
            ra = {1'($urandom), 8'(expa), 23'($urandom)};
            rb = {1'($urandom), 8'(expb), 23'($urandom)};
            case (sel)
                0: ra = {ra[31], 8'($urandom_range(0, 1) * 255), 23'($urandom_range(0, 1) * $urandom)};
                1: rb = {rb[31], 8'($urandom_range(0, 1) * 255), 23'($urandom_range(0, 1) * $urandom)};
                2: begin ra = $urandom; rb = $urandom; end
                3: rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
                4: rb = {1'($urandom), ra[30:0]};
                5: begin
                    ra = {1'($urandom), 8'($urandom_range(253, 254)), 23'($urandom)};
                    rb = {~ra[31] ^ 1'($urandom_range(0, 3) == 0), 8'($urandom_range(253, 254)), 23'($urandom)};
                end
                6: begin
                    ra = {1'($urandom), 8'($urandom_range(1, 3)), 23'($urandom)};
                    rb = {ra[31], 8'($urandom_range(1, 3)), 23'($urandom)};
                end
                default: ;
            endcase
            model(ra, rb, er, ef, el);
            do_op($sformatf("rnd%0d", i), ra, rb, er, ef, el, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
